alu_decode_stage: RTL

Registered, handshaked successor to the combinational ALU-op decoder. Accepts raw 32-bit RV32 instructions from fetch with a valid/ready handshake and decodes the full major opcode itself, so no separate main-decoder 2-bit ALU class is needed. Emits a 5-bit ALU op, an illegal-instruction flag and a pass-through tag through a 2-entry buffer. M and Zbb decode are selectable by parameter. Adds flush and an illegal-instruction counter. Sits between fetch and the execute stage.

---
 rtl/alu_decode_stage.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// Registered RV32 ALU-op decode stage: decodes raw instructions at push time into a
// 2-entry {op, illegal, tag} buffer with valid/ready on both sides, flush and an illegal counter.
module alu_decode_stage #(
    parameter bit ENABLE_M   = 1'b1,
    parameter bit ENABLE_ZBB = 1'b1,
    parameter int TAG_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0]       alu_op_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [15:0]      illegal_cnt_o
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_OR     = 5'd7;
    localparam logic [4:0] OP_AND    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;
    localparam logic [4:0] OP_ROL    = 5'd18;
    localparam logic [4:0] OP_ROR    = 5'd19;
    localparam logic [4:0] OP_MAX    = 5'd20;
    localparam logic [4:0] OP_MAXU   = 5'd21;
    localparam logic [4:0] OP_MIN    = 5'd22;
    localparam logic [4:0] OP_MINU   = 5'd23;
    localparam logic [4:0] OP_REV8   = 5'd24;
    localparam logic [4:0] OP_ORCB   = 5'd25;
    localparam logic [4:0] OP_CPOP   = 5'd26;
    localparam logic [4:0] OP_CTZ    = 5'd27;
    localparam logic [4:0] OP_CLZ    = 5'd28;
    localparam logic [4:0] OP_SEXTB  = 5'd29;
    localparam logic [4:0] OP_SEXTH  = 5'd30;
    localparam logic [4:0] OP_ZEXTH  = 5'd31;

    // Decode results are {illegal, op}; illegal encodings always report op = add.
    localparam logic [5:0] DEC_ILLEGAL = {1'b1, 5'd0};

    function automatic logic [5:0] legal(input logic [4:0] op);
        return {1'b0, op};
    endfunction

    function automatic logic [5:0] decode_reg(input logic [6:0] f7, input logic [2:0] f3,
                                              input logic [4:0] rs2);
        logic [5:0] res;
        res = DEC_ILLEGAL;
        case (f7)
            7'b0000000: begin
                case (f3)
                    3'b000:  res = legal(OP_ADD);
                    3'b001:  res = legal(OP_SLL);
                    3'b010:  res = legal(OP_SLT);
                    3'b011:  res = legal(OP_SLTU);
                    3'b100:  res = legal(OP_XOR);
                    3'b101:  res = legal(OP_SRL);
                    3'b110:  res = legal(OP_OR);
                    3'b111:  res = legal(OP_AND);
                    default: res = DEC_ILLEGAL;
                endcase
            end
            7'b0100000: begin
                case (f3)
                    3'b000:  res = legal(OP_SUB);
                    3'b101:  res = legal(OP_SRA);
                    default: res = DEC_ILLEGAL;
                endcase
            end
            7'b0000001: begin
                if (ENABLE_M) begin
                    case (f3)
                        3'b000:  res = legal(OP_MUL);
                        3'b001:  res = legal(OP_MULH);
                        3'b010:  res = legal(OP_MULHSU);
                        3'b011:  res = legal(OP_MULHU);
                        3'b100:  res = legal(OP_DIV);
                        3'b101:  res = legal(OP_DIVU);
                        3'b110:  res = legal(OP_REM);
                        3'b111:  res = legal(OP_REMU);
                        default: res = DEC_ILLEGAL;
                    endcase
                end else begin
                    res = DEC_ILLEGAL;
                end
            end
            7'b0000101: begin
                if (ENABLE_ZBB) begin
                    case (f3)
                        3'b100:  res = legal(OP_MIN);
                        3'b101:  res = legal(OP_MINU);
                        3'b110:  res = legal(OP_MAX);
                        3'b111:  res = legal(OP_MAXU);
                        default: res = DEC_ILLEGAL;
                    endcase
                end else begin
                    res = DEC_ILLEGAL;
                end
            end
            7'b0110000: begin
                if (ENABLE_ZBB) begin
                    case (f3)
                        3'b001:  res = legal(OP_ROL);
                        3'b101:  res = legal(OP_ROR);
                        default: res = DEC_ILLEGAL;
                    endcase
                end else begin
                    res = DEC_ILLEGAL;
                end
            end
            7'b0000100: begin
                if (ENABLE_ZBB && (f3 == 3'b100) && (rs2 == 5'b00000)) begin
                    res = legal(OP_ZEXTH);
                end else begin
                    res = DEC_ILLEGAL;
                end
            end
            default: res = DEC_ILLEGAL;
        endcase
        return res;
    endfunction

    // Immediate-form shifts and Zbb unary ops, where rs2 is an opcode extension.
    function automatic logic [5:0] decode_imm_shift(input logic [6:0] f7, input logic [2:0] f3,
                                                    input logic [4:0] rs2);
        logic [5:0] res;
        res = DEC_ILLEGAL;
        if (f3 == 3'b001) begin
            if (f7 == 7'b0000000) begin
                res = legal(OP_SLL);
            end else if (ENABLE_ZBB && (f7 == 7'b0110000)) begin
                case (rs2)
                    5'b00000: res = legal(OP_CLZ);
                    5'b00001: res = legal(OP_CTZ);
                    5'b00010: res = legal(OP_CPOP);
                    5'b00100: res = legal(OP_SEXTB);
                    5'b00101: res = legal(OP_SEXTH);
                    default:  res = DEC_ILLEGAL;
                endcase
            end else begin
                res = DEC_ILLEGAL;
            end
        end else begin
            case (f7)
                7'b0000000: res = legal(OP_SRL);
                7'b0100000: res = legal(OP_SRA);
                7'b0110000: res = ENABLE_ZBB ? legal(OP_ROR) : DEC_ILLEGAL;
                7'b0110100: res = (ENABLE_ZBB && (rs2 == 5'b11000)) ? legal(OP_REV8) : DEC_ILLEGAL;
                7'b0010100: res = (ENABLE_ZBB && (rs2 == 5'b00111)) ? legal(OP_ORCB) : DEC_ILLEGAL;
                default:    res = DEC_ILLEGAL;
            endcase
        end
        return res;
    endfunction

    function automatic logic [5:0] decode_imm(input logic [6:0] f7, input logic [2:0] f3,
                                              input logic [4:0] rs2);
        logic [5:0] res;
        res = DEC_ILLEGAL;
        case (f3)
            3'b000:  res = legal(OP_ADD);
            3'b010:  res = legal(OP_SLT);
            3'b011:  res = legal(OP_SLTU);
            3'b100:  res = legal(OP_XOR);
            3'b110:  res = legal(OP_OR);
            3'b111:  res = legal(OP_AND);
            3'b001:  res = decode_imm_shift(f7, f3, rs2);
            3'b101:  res = decode_imm_shift(f7, f3, rs2);
            default: res = DEC_ILLEGAL;
        endcase
        return res;
    endfunction

    function automatic logic [5:0] decode_instr(input logic [31:0] instr);
        logic [5:0] res;
        res = DEC_ILLEGAL;
        case (instr[6:0])
            7'b0110011: res = decode_reg(instr[31:25], instr[14:12], instr[24:20]);
            7'b0010011: res = decode_imm(instr[31:25], instr[14:12], instr[24:20]);
            7'b0000011,
            7'b0100011,
            7'b0010111,
            7'b0110111,
            7'b1101111,
            7'b1100111: res = legal(OP_ADD);
            7'b1100011: res = legal(OP_SUB);
            default:    res = DEC_ILLEGAL;
        endcase
        return res;
    endfunction

    logic [1:0]       count_r;
    logic [4:0]       head_op_r;
    logic             head_ill_r;
    logic [TAG_W-1:0] head_tag_r;
    logic [4:0]       tail_op_r;
    logic             tail_ill_r;
    logic [TAG_W-1:0] tail_tag_r;
    logic [15:0]      ill_cnt_r;
    logic [5:0]       dec_s;
    logic             push_s;
    logic             pop_s;

    assign dec_s       = decode_instr(instr_i);
    assign in_ready_o  = rst_n_i && (count_r != 2'd2) && !flush_i;
    assign out_valid_o = (count_r != 2'd0);
    assign push_s      = in_valid_i && in_ready_o;
    assign pop_s       = out_valid_o && out_ready_i && !flush_i;

    assign alu_op_o      = head_op_r;
    assign illegal_o     = head_ill_r;
    assign tag_o         = head_tag_r;
    assign illegal_cnt_o = ill_cnt_r;

    // Two-slot buffer: head drives the outputs directly, tail backs it up when full.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_r    <= 2'd0;
            head_op_r  <= 5'd0;
            head_ill_r <= 1'b0;
            head_tag_r <= '0;
            tail_op_r  <= 5'd0;
            tail_ill_r <= 1'b0;
            tail_tag_r <= '0;
        end else if (flush_i) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_op_r  <= dec_s[4:0];
                        head_ill_r <= dec_s[5];
                        head_tag_r <= tag_i;
                    end else begin
                        tail_op_r  <= dec_s[4:0];
                        tail_ill_r <= dec_s[5];
                        tail_tag_r <= tag_i;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_op_r  <= tail_op_r;
                        head_ill_r <= tail_ill_r;
                        head_tag_r <= tail_tag_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                // Push with pop only happens at count 1: the new entry replaces the head.
                2'b11: begin
                    head_op_r  <= dec_s[4:0];
                    head_ill_r <= dec_s[5];
                    head_tag_r <= tag_i;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Saturating count of illegal entries handed to execute; survives flush.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ill_cnt_r <= 16'd0;
        end else if (pop_s && head_ill_r && (ill_cnt_r != 16'hFFFF)) begin
            ill_cnt_r <= ill_cnt_r + 16'd1;
        end else begin
            ill_cnt_r <= ill_cnt_r;
        end
    end

endmodule
